// File: rtl/mul_product_combine.sv
// mul_product_combine: recombines signed DSP partial products into SEW-sized
// multiply results (low or high half), accumulating SEW=64 ops over two beats.
module mul_product_combine #(
    parameter int DATA_WIDTH    = 64,
    parameter int PROD_WIDTH    = 36,
    parameter int NUM_PROD      = 8,
    parameter int SEW_WIDTH     = 2,
    parameter bit ENABLE_64_BIT = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PROD*PROD_WIDTH-1:0] prod,
    input  logic [SEW_WIDTH-1:0]           sew,
    input  logic                           hi,
    input  logic                           in_valid,
    output logic [DATA_WIDTH-1:0]          res,
    output logic                           res_valid,
    output logic                           err
);

    localparam int AW = 2 * DATA_WIDTH;   // full-precision product width

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   px [NUM_PROD];
    logic [AW-1:0]   beat_sum;
    logic [AW-1:0]   lane_sum;
    logic [AW-1:0]   acc;
    logic            hi_lat;
    logic            acc_load, acc_fin, take, err_nx;

    logic                 s1_valid;
    logic [SEW_WIDTH-1:0] s1_sew;
    logic                 s1_hi;
    logic [AW-1:0]        s1_sum;
    logic [DATA_WIDTH-1:0] res_nx;

    function automatic logic [AW-1:0] sext(input logic [PROD_WIDTH-1:0] v);
        return {{(AW-PROD_WIDTH){v[PROD_WIDTH-1]}}, v};
    endfunction

    // Sign-extend partials and form the per-SEW full-precision sums
    always_comb begin
        logic [AW-1:0] t;
        beat_sum = '0;
        lane_sum = '0;
        t        = '0;
        for (int k = 0; k < NUM_PROD; k++)
            px[k] = sext(prod[k*PROD_WIDTH +: PROD_WIDTH]);
        // beat-local weights 16*(i+j); beat 1 gets an extra 32 bits of shift
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++)
                beat_sum = beat_sum + (px[4*i+j] << (16*(i+j)));
        case (sew)
            2'b00: for (int k = 0; k < 8; k++)
                       lane_sum[16*k +: 16] = px[k][15:0];
            2'b01: for (int k = 0; k < 4; k++)
                       lane_sum[32*k +: 32] = px[k][31:0];
            default: for (int j = 0; j < 2; j++) begin
                t = px[4*j] + ((px[4*j+1] + px[4*j+2]) << 16) + (px[4*j+3] << 32);
                lane_sum[64*j +: 64] = t[63:0];
            end
        endcase
    end

    // SEW64 beat sequencing: next state and control strobes
    always_comb begin
        state_nx = state;
        acc_load = 1'b0;
        acc_fin  = 1'b0;
        take     = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                if (sew == 2'b11) begin
                    if (ENABLE_64_BIT) begin
                        acc_load = 1'b1;
                        state_nx = ACC;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else begin
                    take = 1'b1;
                end
            end
            ACC: if (in_valid) begin
                state_nx = IDLE;
                if (sew == 2'b11) begin
                    acc_fin = 1'b1;
                end else begin
                    // abandoned SEW64 op; the new beat still runs normally
                    err_nx = 1'b1;
                    take   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Beat-0 accumulator and latched half select
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            hi_lat <= 1'b0;
        end else if (acc_load) begin
            acc    <= beat_sum;
            hi_lat <= hi;
        end
    end

    // Stage 1: registered sums plus error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sew   <= '0;
            s1_hi    <= 1'b0;
            s1_sum   <= '0;
            err      <= 1'b0;
        end else begin
            s1_valid <= take | acc_fin;
            err      <= err_nx;
            if (take | acc_fin) begin
                s1_sew <= sew;
                s1_hi  <= acc_fin ? hi_lat : hi;
                s1_sum <= acc_fin ? acc + (beat_sum << 32) : lane_sum;
            end
        end
    end

    // Lane half-select and packing
    always_comb begin
        res_nx = '0;
        case (s1_sew)
            2'b00: for (int k = 0; k < 8; k++)
                       res_nx[8*k +: 8] = s1_hi ? s1_sum[16*k+8 +: 8] : s1_sum[16*k +: 8];
            2'b01: for (int k = 0; k < 4; k++)
                       res_nx[16*k +: 16] = s1_hi ? s1_sum[32*k+16 +: 16] : s1_sum[32*k +: 16];
            2'b10: for (int k = 0; k < 2; k++)
                       res_nx[32*k +: 32] = s1_hi ? s1_sum[64*k+32 +: 32] : s1_sum[64*k +: 32];
            default: res_nx = s1_hi ? s1_sum[127:64] : s1_sum[63:0];
        endcase
    end

    // Stage 2: result register, held between results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= s1_valid;
            if (s1_valid) res <= res_nx;
        end
    end

endmodule

// File: tb/tb_mul_product_combine.sv
// Directed bench for mul_product_combine with hand-computed expectations.
module tb_mul_product_combine;

    logic         clk = 1'b0;
    logic         rst;
    logic [287:0] prod;
    logic [1:0]   sew;
    logic         hi;
    logic         in_valid;
    logic [63:0]  res, res2;
    logic         res_valid, res_valid2;
    logic         err, err2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_product_combine dut (
        .clk(clk), .rst(rst), .prod(prod), .sew(sew), .hi(hi),
        .in_valid(in_valid), .res(res), .res_valid(res_valid), .err(err)
    );

    mul_product_combine #(.ENABLE_64_BIT(1'b0)) dut_no64 (
        .clk(clk), .rst(rst), .prod(prod), .sew(sew), .hi(hi),
        .in_valid(in_valid), .res(res2), .res_valid(res_valid2), .err(err2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [287:0] rep(input logic [35:0] v, input int n);
        logic [287:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k*36 +: 36] = v;
        return r;
    endfunction

    function automatic logic [287:0] one(input int k, input logic [35:0] v);
        logic [287:0] r;
        r = '0;
        r[k*36 +: 36] = v;
        return r;
    endfunction

    task automatic beat(input logic [1:0] s, input logic h, input logic [287:0] p);
        @(negedge clk);
        in_valid = 1'b1; sew = s; hi = h; prod = p;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // single non-SEW64 op: no result one cycle after, result two cycles after
    task automatic op_single(input string tag, input logic [1:0] s, input logic h,
                             input logic [287:0] p, input logic [63:0] exp);
        beat(s, h, p);
        idle();
        chk({tag, "_rv_early"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
        @(negedge clk);
        chk({tag, "_rv"}, {63'd0, res_valid}, 64'd1);
        chk({tag, "_res"}, res, exp);
    endtask

    logic [287:0] p32;

    initial begin
        rst = 1'b0; in_valid = 1'b0; sew = 2'b00; hi = 1'b0; prod = '0;
        #3;
        chk("rst_res", res, 64'd0);
        chk("rst_rv", {63'd0, res_valid}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // SEW8, -3*5 in every lane
        op_single("s8_lo", 2'b00, 1'b0, rep(36'hFFFFFFFF1, 8), 64'hF1F1_F1F1_F1F1_F1F1);
        op_single("s8_hi", 2'b00, 1'b1, rep(36'hFFFFFFFF1, 8), 64'hFFFF_FFFF_FFFF_FFFF);

        // SEW16 back-to-back, 0x7FFF squared; prod[4..7] carry junk to be ignored
        beat(2'b01, 1'b0, rep(36'h03FFF0001, 4) | one(5, 36'h123456789));
        beat(2'b01, 1'b1, rep(36'h03FFF0001, 4) | one(7, 36'hFFFFFFFFF));
        idle();
        chk("s16_a_rv", {63'd0, res_valid}, 64'd1);
        chk("s16_a_res", res, 64'h0001_0001_0001_0001);
        @(negedge clk);
        chk("s16_b_rv", {63'd0, res_valid}, 64'd1);
        chk("s16_b_res", res, 64'h3FFF_3FFF_3FFF_3FFF);
        @(negedge clk);
        chk("s16_rv_off", {63'd0, res_valid}, 64'd0);
        chk("s16_hold", res, 64'h3FFF_3FFF_3FFF_3FFF);

        // SEW32, a=0xFFFFFFFF, b=2 on both lanes
        p32 = one(0, 36'h1FFFE) | one(2, 36'h1FFFE) | one(4, 36'h1FFFE) | one(6, 36'h1FFFE);
        op_single("s32_lo", 2'b10, 1'b0, p32, 64'hFFFFFFFE_FFFFFFFE);
        op_single("s32_hi", 2'b10, 1'b1, p32, 64'h00000001_00000001);

        // SEW64, a=b=2^32, hi latched at beat 0, three idle cycles between beats
        beat(2'b11, 1'b1, '0);
        idle();
        chk("s64_b0_rv", {63'd0, res_valid}, 64'd0);
        chk("s64_b0_err", {63'd0, err}, 64'd0);
        chk("no64_err", {63'd0, err2}, 64'd1);
        @(negedge clk);
        chk("no64_err_pulse", {63'd0, err2}, 64'd0);
        chk("s64_gap1_rv", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("s64_gap2_rv", {63'd0, res_valid}, 64'd0);
        beat(2'b11, 1'b0, one(2, 36'd1));
        idle();
        chk("s64_b1_rv_early", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("s64_hi_rv", {63'd0, res_valid}, 64'd1);
        chk("s64_hi_res", res, 64'd1);
        chk("no64_rv", {63'd0, res_valid2}, 64'd0);
        @(negedge clk);
        chk("s64_single_pulse", {63'd0, res_valid}, 64'd0);
        beat(2'b11, 1'b0, '0);
        beat(2'b11, 1'b1, one(2, 36'd1));
        idle();
        @(negedge clk);
        chk("s64_lo_rv", {63'd0, res_valid}, 64'd1);
        chk("s64_lo_res", res, 64'd0);

        // Abort: SEW64 beat 0 then an SEW16 op
        beat(2'b11, 1'b0, one(0, 36'd9));
        beat(2'b01, 1'b0, rep(36'd5, 4));
        idle();
        chk("abort_err", {63'd0, err}, 64'd1);
        chk("abort_rv_early", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("abort_err_pulse", {63'd0, err}, 64'd0);
        chk("abort_rv", {63'd0, res_valid}, 64'd1);
        chk("abort_res", res, 64'h0005_0005_0005_0005);
        @(negedge clk);
        chk("abort_no64", {63'd0, res_valid}, 64'd0);
        // a following SEW64 pair: 3 + (2 << 32)
        beat(2'b11, 1'b0, one(0, 36'd3));
        beat(2'b11, 1'b0, one(0, 36'd2));
        idle();
        chk("post_abort_rv_early", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("post_abort_rv", {63'd0, res_valid}, 64'd1);
        chk("post_abort_res", res, 64'h00000002_00000003);

        // Reset while in ACC
        beat(2'b11, 1'b0, one(0, 36'd7));
        idle();
        #2 rst = 1'b0;
        #1;
        chk("midrst_res", res, 64'd0);
        chk("midrst_rv", {63'd0, res_valid}, 64'd0);
        chk("midrst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        beat(2'b11, 1'b0, one(0, 36'd7));
        idle();
        chk("rel_b0_rv1", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("rel_b0_rv2", {63'd0, res_valid}, 64'd0);
        beat(2'b11, 1'b1, one(0, 36'd1));
        idle();
        @(negedge clk);
        chk("rel_done_rv", {63'd0, res_valid}, 64'd1);
        chk("rel_done_res", res, 64'h00000001_00000007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
